// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Purpose  : Multi-cycle shift-add multiplier controller. Owns no adder; each
//            RUN cycle it drives the shared 32-bit ALU with an ADD and
//            captures the combinational result into the accumulator.
//            Produces the low WIDTH bits of A*B (identical for signed and
//            unsigned operands).
// Ports    : clk          in   rising-edge clock
//            rst_n        in   asynchronous active-low reset
//            start        in   multiply request, accepted only in IDLE
//            multiplicand in   operand A, sampled on the accepting edge
//            multiplier   in   operand B, sampled on the accepting edge
//            busy         out  high in RUN and DONE
//            done         out  one-cycle pulse, product valid
//            product      out  low word of A*B, held until next accept
//            alu_op1      out  to ALU operand 1
//            alu_op2      out  to ALU operand 2
//            alu_op       out  to ALU opcode
//            alu_result   in   from ALU result (same cycle)
// Revision : 1.0  initial release
// ============================================================================
module alu_mul_sequencer #(
   parameter int          WIDTH     = 32,
   parameter logic [3:0]  ALUOP_ADD = 4'b0010
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic [WIDTH-1:0] alu_op1,
   output logic [WIDTH-1:0] alu_op2,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q,   acc_d;
   logic [WIDTH-1:0]   m_q,     m_d;
   logic [WIDTH-1:0]   q_q,     q_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [WIDTH-1:0]   q_shift;

   assign q_shift = q_q >> 1;
   assign product = acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         m_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      m_d     = m_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      done    = 1'b0;
      alu_op1 = '0;
      alu_op2 = '0;
      alu_op  = ALUOP_ADD;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d     = multiplicand;
               q_d     = multiplier;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy    = 1'b1;
            alu_op1 = acc_q;
            // Add the shifted multiplicand only when the current multiplier LSB is set
            alu_op2 = q_q[0] ? m_q : '0;
            acc_d   = alu_result;
            m_d     = m_q << 1;
            q_d     = q_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            // Stop early once no set multiplier bits remain
            if ((q_shift == '0) || (cnt_q == CNT_LAST)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
